// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and default constants for the MEM pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          WORD_BYTES      = 4;
  localparam int          DEF_DEPTH       = 64;
  localparam int          DEF_WAIT_CYCLES = 4;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;

  // Width of a counter/index that must be at least one bit wide.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : EXE -> MEM request bundle and MEM -> WB result bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;

  logic        WB_EN;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_Res;
  logic [31:0] Val_Rm;
  logic [3:0]  Dest;

  logic        WB_EN_out;
  logic        MEM_R_EN_out;
  logic [31:0] ALU_Res_out;
  logic [3:0]  Dest_out;
  logic [31:0] Mem_Data;
  logic        ready;

  modport master (
    output WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest,
    input  WB_EN_out, MEM_R_EN_out, ALU_Res_out, Dest_out, Mem_Data, ready
  );

  modport slave (
    input  WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest,
    output WB_EN_out, MEM_R_EN_out, ALU_Res_out, Dest_out, Mem_Data, ready
  );

endinterface
`default_nettype wire

// File: rtl/data_sram.sv
`default_nettype none
// ============================================================================
// Module      : data_sram
// Description : Single-port data memory, synchronous write and read, cleared
//               by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          we,
  input  wire logic          re,
  input  wire logic [AW-1:0] idx,
  input  wire logic [31:0]   wdata,
  output logic      [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[idx];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage: multi-cycle load/store with upstream
//               freeze via ready. Optional sticky out-of-range flag when
//               MEM_STAGE_OOR_ERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_pkg::*;
#(
  parameter int          DEPTH       = DEF_DEPTH,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  mem_stage_if.slave bus
`ifdef MEM_STAGE_OOR_ERR_EN
  ,
  output logic       oor_err
`endif
);

  localparam int                 c_addr_w   = clog2_min1(DEPTH);
  localparam int                 c_cnt_w    = clog2_min1(WAIT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WAIT_CYCLES - 1);
  localparam logic [31:0]        c_span     = 32'(WORD_BYTES * DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic                w_ready;

  logic                w_req;
  logic                w_is_load;
  logic [31:0]         w_off;
  logic                w_in_range;
  logic [c_addr_w-1:0] w_idx;
  logic                w_last;

  logic                r_zero;
  logic [31:0]         w_rdata;

  assign bus.WB_EN_out    = bus.WB_EN;
  assign bus.MEM_R_EN_out = bus.MEM_R_EN;
  assign bus.ALU_Res_out  = bus.ALU_Res;
  assign bus.Dest_out     = bus.Dest;

  // A simultaneous read+write request is a store, so only a pure read loads.
  assign w_req      = bus.MEM_R_EN | bus.MEM_W_EN;
  assign w_is_load  = bus.MEM_R_EN & ~bus.MEM_W_EN;
  assign w_off      = bus.ALU_Res - BASE_ADDR;
  assign w_in_range = (bus.ALU_Res >= BASE_ADDR) && (w_off < c_span);
  assign w_idx      = w_off[c_addr_w+1:2];
  assign w_last     = (r_state == BUSY) && (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = ~w_req;
        if (w_req) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (r_cnt == c_cnt_last) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      DONE: begin
        w_ready     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ready = w_ready;

  data_sram #(
    .DEPTH (DEPTH),
    .AW    (c_addr_w)
  ) u_data_sram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_last & bus.MEM_W_EN & w_in_range),
    .re    (w_last & w_is_load & w_in_range),
    .idx   (w_idx),
    .wdata (bus.Val_Rm),
    .rdata (w_rdata)
  );

  // Loads that return no memory word (out of range, or read+write) force zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
    end else if (w_last && bus.MEM_R_EN) begin
      r_zero <= ~(w_is_load & w_in_range);
    end
  end

  assign bus.Mem_Data = r_zero ? 32'd0 : w_rdata;

`ifdef MEM_STAGE_OOR_ERR_EN
  logic r_oor_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oor_err <= 1'b0;
    end else if (w_last && !w_in_range) begin
      r_oor_err <= 1'b1;
    end
  end

  assign oor_err = r_oor_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int c_lows = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  mem_stage_if bus ();

`ifdef MEM_STAGE_OOR_ERR_EN
  logic oor_err;
`endif

  always #5 clk = ~clk;

  mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_STAGE_OOR_ERR_EN
    ,
    .oor_err (oor_err)
`endif
  );

  // Request inputs must stay frozen for as long as ready stays low.
  logic        r_in_acc = 1'b0;
  logic [69:0] r_prev_req;
  always @(posedge clk) begin
    if (!rst_n) begin
      r_in_acc <= 1'b0;
    end else begin
      if (r_in_acc && !bus.ready) begin
        assert ({bus.MEM_R_EN, bus.MEM_W_EN, bus.ALU_Res, bus.Val_Rm, bus.Dest} == r_prev_req)
          else $error("request inputs changed while stage is frozen");
      end
      r_in_acc <= !bus.ready;
    end
    r_prev_req <= {bus.MEM_R_EN, bus.MEM_W_EN, bus.ALU_Res, bus.Val_Rm, bus.Dest};
  end

  task automatic drive(input logic wb, input logic r, input logic w,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] dest);
    @(negedge clk);
    bus.WB_EN    = wb;
    bus.MEM_R_EN = r;
    bus.MEM_W_EN = w;
    bus.ALU_Res  = addr;
    bus.Val_Rm   = data;
    bus.Dest     = dest;
    #1;
  endtask

  // Presents one request and returns how many cycles ready was low; ends in DONE.
  task automatic access(input logic wb, input logic r, input logic w,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] dest, output int lows);
    drive(wb, r, w, addr, data, dest);
    lows = 0;
    while (!bus.ready && lows < 20) begin
      lows++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.WB_EN = 1'b0; bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0;
    bus.ALU_Res = 32'h0000_1234; bus.Val_Rm = 32'd0; bus.Dest = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.ALU_Res_out !== 32'h0000_1234) begin
      n_fail++; $display("FAIL reset_passthru: got %h want %h", bus.ALU_Res_out, 32'h1234);
    end
    n_cmp++;
    if (bus.Mem_Data !== 32'd0) begin
      n_fail++; $display("FAIL reset_mem_data: got %h want 0", bus.Mem_Data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready);
    end
`ifdef MEM_STAGE_OOR_ERR_EN
    n_cmp++;
    if (oor_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_oor_err: got %b want 0", oor_err);
    end
`endif
    idle();
    idle();
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.Mem_Data !== 32'd0) begin
      n_fail++; $display("FAIL idle_after_reset: got ready=%b data=%h want 1/0", bus.ready, bus.Mem_Data);
    end
  endtask

  task automatic test_store_load();
    int lows;
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd1, lows);
    n_cmp++;
    if (lows !== c_lows || bus.ready !== 1'b1) begin
      n_fail++; $display("FAIL store_latency: got lows=%0d ready=%b want %0d/1", lows, bus.ready, c_lows);
    end
    idle();
    access(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd2, lows);
    n_cmp++;
    if (lows !== c_lows) begin
      n_fail++; $display("FAIL load_latency: got %0d want %0d", lows, c_lows);
    end
    n_cmp++;
    if (bus.Mem_Data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_1028: got %h want deadbeef", bus.Mem_Data);
    end
    idle();
    n_cmp++;
    if (bus.Mem_Data !== 32'hDEADBEEF || bus.ready !== 1'b1) begin
      n_fail++; $display("FAIL load_hold: got data=%h ready=%b want deadbeef/1", bus.Mem_Data, bus.ready);
    end
  endtask

  task automatic test_top_word();
    int lows;
    access(1'b0, 1'b0, 1'b1, 32'd1276, 32'h12345678, 4'd0, lows);
    idle();
    access(1'b1, 1'b1, 1'b0, 32'd1276, 32'd0, 4'd3, lows);
    n_cmp++;
    if (bus.Mem_Data !== 32'h12345678) begin
      n_fail++; $display("FAIL load_1276: got %h want 12345678", bus.Mem_Data);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    int lows;
`ifdef MEM_STAGE_OOR_ERR_EN
    n_cmp++;
    if (oor_err !== 1'b0) begin
      n_fail++; $display("FAIL oor_err_clear: got %b want 0", oor_err);
    end
`endif
    access(1'b0, 1'b0, 1'b1, 32'd1280, 32'hFFFF0000, 4'd0, lows);
    n_cmp++;
    if (lows !== c_lows) begin
      n_fail++; $display("FAIL oor_latency: got %0d want %0d", lows, c_lows);
    end
`ifdef MEM_STAGE_OOR_ERR_EN
    n_cmp++;
    if (oor_err !== 1'b1) begin
      n_fail++; $display("FAIL oor_err_set: got %b want 1", oor_err);
    end
`endif
    idle();
    access(1'b0, 1'b0, 1'b1, 32'd1020, 32'h0000FFFF, 4'd0, lows);
    idle();
    access(1'b1, 1'b1, 1'b0, 32'd1280, 32'd0, 4'd4, lows);
    n_cmp++;
    if (bus.Mem_Data !== 32'd0) begin
      n_fail++; $display("FAIL load_1280: got %h want 0", bus.Mem_Data);
    end
    idle();
    access(1'b1, 1'b1, 1'b0, 32'd1276, 32'd0, 4'd4, lows);
    n_cmp++;
    if (bus.Mem_Data !== 32'h12345678) begin
      n_fail++; $display("FAIL word63_intact: got %h want 12345678", bus.Mem_Data);
    end
    idle();
    access(1'b1, 1'b1, 1'b0, 32'd1020, 32'd0, 4'd4, lows);
    n_cmp++;
    if (bus.Mem_Data !== 32'd0) begin
      n_fail++; $display("FAIL load_1020: got %h want 0", bus.Mem_Data);
    end
    idle();
    access(1'b1, 1'b1, 1'b0, 32'd1276, 32'd0, 4'd4, lows);
    idle();
    access(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd4, lows);
    n_cmp++;
    if (bus.Mem_Data !== 32'd0) begin
      n_fail++; $display("FAIL word0_intact: got %h want 0", bus.Mem_Data);
    end
    idle();
`ifdef MEM_STAGE_OOR_ERR_EN
    n_cmp++;
    if (oor_err !== 1'b1) begin
      n_fail++; $display("FAIL oor_err_sticky: got %b want 1", oor_err);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lows;
    access(1'b0, 1'b0, 1'b1, 32'd1032, 32'h0BADF00D, 4'd7, lows);
    n_cmp++;
    if (bus.Dest_out !== 4'd7 || bus.WB_EN_out !== 1'b0 || bus.ALU_Res_out !== 32'd1032) begin
      n_fail++; $display("FAIL b2b_passthru1: got dest=%h wb=%b alu=%h want 7/0/408",
                         bus.Dest_out, bus.WB_EN_out, bus.ALU_Res_out);
    end
    access(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd9, lows);
    n_cmp++;
    if (lows !== c_lows) begin
      n_fail++; $display("FAIL b2b_latency: got %0d want %0d", lows, c_lows);
    end
    n_cmp++;
    if (bus.Mem_Data !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL b2b_load: got %h want 0badf00d", bus.Mem_Data);
    end
    n_cmp++;
    if (bus.Dest_out !== 4'd9 || bus.WB_EN_out !== 1'b1 || bus.MEM_R_EN_out !== 1'b1) begin
      n_fail++; $display("FAIL b2b_passthru2: got dest=%h wb=%b rd=%b want 9/1/1",
                         bus.Dest_out, bus.WB_EN_out, bus.MEM_R_EN_out);
    end
    idle();
  endtask

  task automatic test_read_write_both();
    int lows;
    access(1'b0, 1'b1, 1'b1, 32'd1040, 32'hA5A5A5A5, 4'd0, lows);
    n_cmp++;
    if (bus.Mem_Data !== 32'd0 || lows !== c_lows) begin
      n_fail++; $display("FAIL both_mem_data: got %h lows=%0d want 0/%0d", bus.Mem_Data, lows, c_lows);
    end
    idle();
    access(1'b1, 1'b1, 1'b0, 32'd1040, 32'd0, 4'd0, lows);
    n_cmp++;
    if (bus.Mem_Data !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL both_written: got %h want a5a5a5a5", bus.Mem_Data);
    end
    idle();
  endtask

  task automatic test_non_mem();
    int lows;
    int bad = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd1028, 32'h11111111, 4'd3);
      if (bus.ready !== 1'b1 || bus.Mem_Data !== 32'hA5A5A5A5) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL non_mem_ready: got %0d bad cycles want 0", bad);
    end
    access(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd0, lows);
    n_cmp++;
    if (bus.Mem_Data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL non_mem_no_write: got %h want deadbeef", bus.Mem_Data);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    int lows;
    drive(1'b0, 1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 4'd5);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0; bus.ALU_Res = 32'd0;
    #1;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.Mem_Data !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset_ready: got ready=%b data=%h want 1/0", bus.ready, bus.Mem_Data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    access(1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd0, lows);
    n_cmp++;
    if (bus.Mem_Data !== 32'd0 || lows !== c_lows) begin
      n_fail++; $display("FAIL mid_reset_load: got %h lows=%0d want 0/%0d", bus.Mem_Data, lows, c_lows);
    end
    idle();
`ifdef MEM_STAGE_OOR_ERR_EN
    n_cmp++;
    if (oor_err !== 1'b0) begin
      n_fail++; $display("FAIL oor_err_reset: got %b want 0", oor_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_top_word();
    test_out_of_range();
    test_back_to_back();
    test_read_write_both();
    test_non_mem();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
